reg_op_sequencer: RTL and testbench
===================================

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, data width; matches the register file data width.
REQ-002 Parameter ADDR_W, default 3, register address width, giving 8 registers.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  1  operation request present.
REQ-006 req_ready  out  1  sequencer can accept a request.
REQ-007 req_op  in  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 req_src_a, req_src_b, req_dst  in  ADDR_W each  operand and destination register addresses.
REQ-009 rf_read_enable  out  1  register file read enable.
REQ-010 rf_read_addr  out  ADDR_W  register file read address.
REQ-011 rf_read_data  in  WIDTH  register file read data; valid after the negedge of a cycle with rf_read_enable=1, Z otherwise.
REQ-012 rf_write_enable, rf_write_addr, rf_write_data  out  1/ADDR_W/WIDTH  register file write port; the register file writes on posedge.
REQ-013 done  out  1  one-cycle pulse in the write-back cycle.
REQ-014 result  out  WIDTH  last computed result; held until the next write-back.

Function
REQ-015 The FSM SHALL have states IDLE, RD_A, RD_B, EXEC and WB.
- IDLE -> RD_A on req_valid & req_ready.
- Fixed sequence: RD_A -> RD_B -> EXEC -> WB -> IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; on acceptance, op/src_a/src_b/dst SHALL be latched, and later request changes are ignored.
REQ-017 In RD_A: rf_read_enable=1 and rf_read_addr=src_a; rf_read_data SHALL be captured into operand A at the posedge ending RD_A. RD_B does the same with src_b into operand B.
REQ-018 rf_read_data SHALL be sampled only at the end of RD_A and RD_B; Z on the bus at any other time SHALL NOT affect state.
REQ-019 In EXEC the result SHALL be registered as: ADD = (A+B) mod 2^WIDTH, SUB = (A-B) mod 2^WIDTH (wrap-around), AND, OR.
REQ-020 In WB:
- rf_write_enable=1, rf_write_addr=dst, rf_write_data=result;
- done=1 for exactly that cycle.
REQ-021 Outside WB, rf_write_enable=0. Outside RD_A/RD_B, rf_read_enable=0.
REQ-022 Latency: a request accepted at posedge N gives done=1 in cycle N+4; the next acceptance is possible at posedge N+5.
REQ-023 src_a==src_b, dst==src_a and dst==src_b are all legal; operands SHALL be the pre-write values.
REQ-024 Back-to-back requests SHALL read values written by the preceding WB, because that write completes before the next RD_A.

Reset
REQ-025 While rst=1 at a posedge:
- state goes to IDLE;
- operands and result clear to 0;
- done, rf_read_enable and rf_write_enable are 0;
- req_ready is 0.
req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Reset in any state SHALL abort the operation with no register file write, including reset asserted during WB (the write is suppressed in that cycle).

Configuration
REQ-027 When REG_OP_FLAGS_EN is defined, the block SHALL add:
- outputs zero_flag (result==0) and carry_flag (carry-out of ADD, borrow of SUB, 0 for AND/OR);
- both flags registered in EXEC, held like result, and reset to 0.
When REG_OP_FLAGS_EN is undefined, these ports and their logic SHALL be absent.

Structure
REQ-028 Package reg_op_pkg SHALL hold the op-code enum, the FSM state enum, and default WIDTH/ADDR_W constants.
REQ-029 Combinational sub-module reg_op_alu (op, a, b -> result[, carry]) SHALL be instantiated once by reg_op_sequencer.

Verification
REQ-030 The bench SHALL pair the sequencer with a behavioural 8x16 register file (posedge write, negedge read, Z when read is disabled) and cover:
- Reset with req_valid=1: no rf enables, req_ready=0; req_ready=1 in the cycle after release.
- Preload R1=0x0005, R2=0x0003; ADD src 1,2 dst 3 -> done in cycle N+4, R3=0x0008, result=0x0008.
- SUB src 2,1 dst 4 -> R4=0xFFFE (wrap); with REG_OP_FLAGS_EN, carry_flag=1 and zero_flag=0.
- AND R1,R1 into R1 immediately followed by OR R1,R2 into R5 -> R1=0x0005, R5=0x0007, req_ready gaps exactly 4 cycles.
- rst asserted during RD_B of ADD into R6 (preloaded 0x1234) -> R6 remains 0x1234, done never pulses.
- req_valid toggling and req_src changes during RD_A..WB -> ignored; write address = the latched dst.

Source files
------------

// File: rtl/reg_op_pkg.sv
// Shared types for the register-operation sequencer: op codes, FSM states, default sizes.
// The optional REG_OP_FLAGS_EN build adds zero/carry flags to the sequencer and ALU.
package reg_op_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/reg_op_alu.sv
// Combinational ALU for the sequencer: ADD/SUB wrap modulo 2^WIDTH, AND, OR.
// Latency: none (pure combinational). Backpressure: n/a. REG_OP_FLAGS_EN adds carry (ADD carry-out / SUB borrow).
module reg_op_alu
  import reg_op_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
`ifdef REG_OP_FLAGS_EN
  ,
  output logic             carry
`endif
);

`ifdef REG_OP_FLAGS_EN
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra top bit of the zero-extended difference is the borrow.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign carry = (op == OP_ADD) ? sum[WIDTH] :
                 (op == OP_SUB) ? diff[WIDTH] : 1'b0;
`else
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;
`endif

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = sum[WIDTH-1:0];
      OP_SUB:  result = diff[WIDTH-1:0];
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Sequences one register op: read A, read B, execute, write back; REG_OP_FLAGS_EN adds zero/carry flags.
// Latency: accept at posedge N, done in the cycle ending at posedge N+4. Backpressure: req_ready only in IDLE.
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_src_a,
  input  logic [ADDR_W-1:0] req_src_b,
  input  logic [ADDR_W-1:0] req_dst,
  output logic              rf_read_enable,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [WIDTH-1:0]  rf_read_data,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [WIDTH-1:0]  rf_write_data,
  output logic              done,
  output logic [WIDTH-1:0]  result
`ifdef REG_OP_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              carry_flag
`endif
);

  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic [WIDTH-1:0]  opa_q;
  logic [WIDTH-1:0]  opb_q;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  alu_res;

`ifdef REG_OP_FLAGS_EN
  logic alu_carry;
  logic zero_q;
  logic carry_q;

  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
`endif

  reg_op_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_res)
`ifdef REG_OP_FLAGS_EN
    ,
    .carry  (alu_carry)
`endif
  );

  // Read data is only captured in RD_A/RD_B, so a floating bus elsewhere never reaches state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
`ifdef REG_OP_FLAGS_EN
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state   <= ST_RD_A;
            op_q    <= op_e'(req_op);
            src_a_q <= req_src_a;
            src_b_q <= req_src_b;
            dst_q   <= req_dst;
          end
        end
        ST_RD_A: begin
          opa_q <= rf_read_data;
          state <= ST_RD_B;
        end
        ST_RD_B: begin
          opb_q <= rf_read_data;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= alu_res;
`ifdef REG_OP_FLAGS_EN
          zero_q   <= (alu_res == '0);
          carry_q  <= alu_carry;
`endif
          state    <= ST_WB;
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // rst gates the strobes directly so a reset landing in WB suppresses that cycle's write.
  assign req_ready       = (state == ST_IDLE) && !rst;
  assign rf_read_enable  = ((state == ST_RD_A) || (state == ST_RD_B)) && !rst;
  assign rf_read_addr    = (state == ST_RD_B) ? src_b_q : src_a_q;
  assign rf_write_enable = (state == ST_WB) && !rst;
  assign rf_write_addr   = dst_q;
  assign rf_write_data   = result_q;
  assign done            = rf_write_enable;
  assign result          = result_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer with a behavioural 8x16 register file and a reference model.
// Define REG_OP_FLAGS_EN on both bench and RTL to also check zero/carry flags.
module tb_reg_op_sequencer;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_src_a;
  logic [AW-1:0] req_src_b;
  logic [AW-1:0] req_dst;
  logic          rf_read_enable;
  logic [AW-1:0] rf_read_addr;
  wire  [W-1:0]  rf_read_data;
  logic          rf_write_enable;
  logic [AW-1:0] rf_write_addr;
  logic [W-1:0]  rf_write_data;
  logic          done;
  logic [W-1:0]  result;
`ifdef REG_OP_FLAGS_EN
  logic          zero_flag;
  logic          carry_flag;
`endif

  always #5 clk = ~clk;

  reg_op_sequencer #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_src_a       (req_src_a),
    .req_src_b       (req_src_b),
    .req_dst         (req_dst),
    .rf_read_enable  (rf_read_enable),
    .rf_read_addr    (rf_read_addr),
    .rf_read_data    (rf_read_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .done            (done),
    .result          (result)
`ifdef REG_OP_FLAGS_EN
    ,
    .zero_flag       (zero_flag),
    .carry_flag      (carry_flag)
`endif
  );

  // Behavioural register file: posedge write, negedge read, Z when not reading.
  logic [W-1:0]  mem [8];
  logic          rd_oe;
  logic [W-1:0]  rd_q;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [W-1:0]  pre_dat;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;
  end

  always @(negedge clk) begin
    rd_oe <= rf_read_enable;
    rd_q  <= mem[rf_read_addr];
  end

  assign rf_read_data = rd_oe ? rd_q : 'z;

  int           vectors    = 0;
  int           miscompares = 0;
  logic [W-1:0] model [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input int unsigned d);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_dat  = W'(d);
    @(posedge clk); #1;
    pre_we   = 1'b0;
    model[a] = W'(d);
  endtask

  // Reference arithmetic on plain integers: wrap modulo 2^16, carry-out / borrow.
  function automatic void ref_op(input int op, input int unsigned x, input int unsigned y,
                                 output int unsigned r, output bit cy);
    r  = 0;
    cy = 1'b0;
    case (op)
      0: begin r = (x + y) % 65536; cy = (x + y) >= 65536; end
      1: begin cy = (x < y); r = cy ? (x + 65536 - y) : (x - y); end
      2: r = x & y;
      default: r = x | y;
    endcase
  endfunction

  // abort_at: 0 = run to completion, k = assert rst in the k-th cycle after acceptance.
  task automatic run_op(input int op, input int a, input int b, input int d,
                        input bit scramble, input int abort_at);
    int unsigned r;
    bit          cy;
    int          lat;
    ref_op(op, model[a], model[b], r, cy);

    for (int i = 0; i < 10 && !req_ready; i++) begin @(posedge clk); #1; end
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_src_a = AW'(a);
    req_src_b = AW'(b);
    req_dst   = AW'(d);
    @(posedge clk); #1;

    for (lat = 1; lat <= 8; lat++) begin
      if (abort_at == lat) begin
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("abort_no_write", rf_write_enable, 0);
        chk("abort_no_done", done, 0);
        repeat (2) begin
          @(posedge clk); #1;
          chk("abort_ready_low", req_ready, 0);
          chk("abort_no_read", rf_read_enable, 0);
          chk("abort_no_done_rst", done, 0);
        end
        rst = 1'b0;
        #1;
        chk("ready_after_abort", req_ready, 1);
        chk("abort_rf_kept", mem[d], model[d]);
        chk("abort_result_clr", result, 0);
        return;
      end
      if (lat == 1) begin
        chk("rd_a_en", rf_read_enable, 1);
        chk("rd_a_addr", rf_read_addr, a);
      end else if (lat == 2) begin
        chk("rd_b_en", rf_read_enable, 1);
        chk("rd_b_addr", rf_read_addr, b);
      end else if (lat == 3) begin
        chk("exec_no_read", rf_read_enable, 0);
      end
      chk("ready_busy", req_ready, 0);
      if (done) break;
      chk("no_write_busy", rf_write_enable, 0);
      req_valid = scramble ? 1'($urandom % 2) : 1'b0;
      if (scramble) begin
        req_op    = 2'($urandom);
        req_src_a = AW'($urandom);
        req_src_b = AW'($urandom);
        req_dst   = AW'($urandom);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;

    chk("done_latency", lat, 4);
    chk("wb_en", rf_write_enable, 1);
    chk("wb_addr", rf_write_addr, d);
    chk("wb_data", rf_write_data, r);
    chk("result_wb", result, r);
`ifdef REG_OP_FLAGS_EN
    chk("zero_flag", zero_flag, (r == 0));
    chk("carry_flag", carry_flag, cy);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("ready_idle", req_ready, 1);
    chk("result_held", result, r);
    chk("rf_written", mem[d], r);
    model[d] = W'(r);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_src_a = 3'd1;
    req_src_b = 3'd2;
    req_dst   = 3'd3;
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_dat   = '0;

    for (int i = 0; i < 8; i++) preload(i, $urandom % 65536);
    chk("rst_ready", req_ready, 0);
    chk("rst_rd_en", rf_read_enable, 0);
    chk("rst_wr_en", rf_write_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
`ifdef REG_OP_FLAGS_EN
    chk("rst_zero", zero_flag, 0);
    chk("rst_carry", carry_flag, 0);
`endif
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("ready_after_reset", req_ready, 1);

    preload(1, 16'h0005);
    preload(2, 16'h0003);
    preload(6, 16'h1234);

    run_op(0, 1, 2, 3, 1'b0, 0);
    chk("r3_add", mem[3], 16'h0008);
    chk("add_result", result, 16'h0008);
    run_op(1, 2, 1, 4, 1'b0, 0);
    chk("r4_sub_wrap", mem[4], 16'hFFFE);
    run_op(2, 1, 1, 1, 1'b0, 0);
    run_op(3, 1, 2, 5, 1'b0, 0);
    chk("r1_and", mem[1], 16'h0005);
    chk("r5_or", mem[5], 16'h0007);

    run_op(0, 1, 2, 6, 1'b0, 2);
    chk("r6_kept", mem[6], 16'h1234);
    run_op(3, 1, 2, 7, 1'b0, 4);
    run_op(0, 4, 4, 4, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom % 4), int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
             1'($urandom % 2), ($urandom % 8 == 0) ? int'(1 + $urandom % 4) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
